hamming_encoder: RTL and testbench

Pipelined SECDED encoder at the write side of the encoder/decoder datapath. It accepts a data word and a size selector (small/medium/large) and produces the 32-bit codeword that the decoder's syndrome and error-fix stages consume. It uses a valid/ready handshake on both sides, runs at full throughput, and supports backpressure.

---
 rtl/hamming_encoder.sv | 155 +++++++++++++++
 tb/tb_hamming_encoder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder.sv
// SECDED encoder for the write side of the codec datapath.
// Two register stages: S1 captures the masked data word and its size, and S2
// holds the finished codeword. Both use a valid/ready handshake with
// full-throughput backpressure. In the illegal size mode the word still flows
// through, with a zero codeword and out_err set.
module hamming_encoder #(
   parameter int AMBA_WORD = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AMBA_WORD-1:0] in_data,
   input  logic [1:0]           in_size,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AMBA_WORD-1:0] out_code,
   output logic                 out_err,
   output logic [CNT_WIDTH-1:0] enc_count
);

   localparam logic [1:0] SZ_SMALL  = 2'b00;
   localparam logic [1:0] SZ_MEDIUM = 2'b01;
   localparam logic [1:0] SZ_LARGE  = 2'b10;

   // Each data bit i is assigned the i-th 5-bit column of weight >= 2
   // (3, 5, 6, 7, 9, ...). Bit j of these masks marks the data bits whose
   // column has bit j set.
   localparam logic [25:0] PMASK0 = 26'h2AAAD5B;
   localparam logic [25:0] PMASK1 = 26'h333366D;
   localparam logic [25:0] PMASK2 = 26'h3C3C78E;
   localparam logic [25:0] PMASK3 = 26'h3FC07F0;
   localparam logic [25:0] PMASK4 = 26'h3FFF800;

   function automatic logic [25:0] mask_data(input logic [AMBA_WORD-1:0] d,
                                             input logic [1:0] sz);
      logic [25:0] m;
      case (sz)
         SZ_SMALL:  m = {18'b0, d[7:0]};
         SZ_MEDIUM: m = {10'b0, d[15:0]};
         SZ_LARGE:  m = d[25:0];
         default:   m = '0;
      endcase
      return m;
   endfunction

   function automatic logic [4:0] ham_parity(input logic [25:0] d);
      logic [4:0] p;
      p[0] = ^(d & PMASK0);
      p[1] = ^(d & PMASK1);
      p[2] = ^(d & PMASK2);
      p[3] = ^(d & PMASK3);
      p[4] = ^(d & PMASK4);
      return p;
   endfunction

   // Data bits above K are already zero, so they do not affect the parity.
   function automatic logic [AMBA_WORD-1:0] encode(input logic [25:0] d,
                                                   input logic [1:0] sz);
      logic [AMBA_WORD-1:0] c;
      logic [4:0]           p;
      p = ham_parity(d);
      c = '0;
      case (sz)
         SZ_SMALL: begin
            c[7:0]  = d[7:0];
            c[11:8] = p[3:0];
            c[12]   = ^{d[7:0], p[3:0]};
         end
         SZ_MEDIUM: begin
            c[15:0]  = d[15:0];
            c[20:16] = p;
            c[21]    = ^{d[15:0], p};
         end
         SZ_LARGE: begin
            c[25:0]  = d;
            c[30:26] = p;
            c[31]    = ^{d, p};
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   logic                 s1_valid_q, s1_valid_d;
   logic [25:0]          s1_data_q, s1_data_d;
   logic [1:0]           s1_size_q, s1_size_d;
   logic                 out_valid_q, out_valid_d;
   logic [AMBA_WORD-1:0] out_code_q, out_code_d;
   logic                 out_err_q, out_err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 s2_adv;
   logic                 s1_take;

   // Handshake steering and next-state for both stages and the counter.
   always_comb begin
      s2_adv      = !out_valid_q || out_ready;
      s1_take     = !s1_valid_q || s2_adv;
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_size_d   = s1_size_q;
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_err_d   = out_err_q;
      cnt_d       = cnt_q;
      if (s1_take) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = mask_data(in_data, in_size);
            s1_size_d = in_size;
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_code_d = encode(s1_data_q, s1_size_q);
            out_err_d  = (s1_size_q == 2'b11);
         end
      end
      if (out_valid_q && out_ready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Control, S2 codeword and counter: cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_err_q   <= out_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // S1 payload; its contents only matter while s1_valid_q is set.
   always_ff @(posedge clk) begin
      s1_data_q <= s1_data_d;
      s1_size_q <= s1_size_d;
   end

   assign in_ready  = s1_take;
   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_err   = out_err_q;
   assign enc_count = cnt_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Scoreboard bench for hamming_encoder: the driver pushes expected codewords
// on acceptance, and the monitor pops and compares on every output transfer.
// A second instance with a 4-bit counter shares the stimulus to exercise the
// counter wrap.
module tb_hamming_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_code;
   logic        out_err;
   logic [15:0] enc_count;

   logic        w4_in_ready;
   logic        w4_out_valid;
   logic [31:0] w4_out_code;
   logic        w4_out_err;
   logic [3:0]  w4_enc_count;

   hamming_encoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_size(in_size), .out_valid(out_valid),
      .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
      .enc_count(enc_count)
   );

   hamming_encoder #(.AMBA_WORD(32), .CNT_WIDTH(4)) dut_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w4_in_ready),
      .in_data(in_data), .in_size(in_size), .out_valid(w4_out_valid),
      .out_ready(out_ready), .out_code(w4_out_code), .out_err(w4_out_err),
      .enc_count(w4_enc_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] code;
      logic        err;
      logic [1:0]  size;
   } exp_t;

   exp_t exp_q[$];
   int   pop_log[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   last_acc_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // i-th 5-bit value of weight >= 2, ascending.
   function automatic int col_of(input int i);
      int idx = 0;
      for (int v = 3; v < 32; v++) begin
         if ($countones(v) >= 2) begin
            if (idx == i) return v;
            idx++;
         end
      end
      return 0;
   endfunction

   function automatic logic [31:0] ref_code(input logic [31:0] d, input logic [1:0] s);
      int          k, np, c;
      logic [4:0]  p;
      logic        ov;
      logic [31:0] r;
      if (s == 2'b11) return 32'h0;
      k  = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 26;
      np = (s == 2'b00) ? 4 : 5;
      p = '0; ov = 1'b0; r = '0;
      for (int i = 0; i < k; i++) begin
         r[i] = d[i];
         if (d[i]) begin
            c  = col_of(i);
            p  = p ^ c[4:0];
            ov = ~ov;
         end
      end
      for (int j = 0; j < np; j++) begin
         r[k+j] = p[j];
         ov     = ov ^ p[j];
      end
      r[k+np] = ov;
      return r;
   endfunction

   // {overall parity, 5-bit Hamming syndrome} of a received word.
   function automatic logic [5:0] syn6(input logic [31:0] w, input int k, input int np);
      logic [4:0] p;
      logic       ov;
      int         c;
      p = '0; ov = 1'b0;
      for (int i = 0; i < k; i++) begin
         if (w[i]) begin
            c = col_of(i);
            p = p ^ c[4:0];
         end
      end
      for (int j = 0; j < np; j++) p[j] = p[j] ^ w[k+j];
      for (int b = 0; b < k + np + 1; b++) ov = ov ^ w[b];
      return {ov, p};
   endfunction

   // Clean word has zero syndrome and zero padding; each single flip gives its column.
   function automatic bit synd_ok(input logic [31:0] code, input logic [1:0] s);
      int          k, np, len, c;
      logic [31:0] w;
      logic [5:0]  es;
      k   = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 26;
      np  = (s == 2'b00) ? 4 : 5;
      len = k + np + 1;
      if (syn6(code, k, np) != 6'd0) return 1'b0;
      for (int b = len; b < 32; b++) if (code[b]) return 1'b0;
      for (int b = 0; b < len; b++) begin
         w = code;
         w[b] = ~w[b];
         if (b < k) begin
            c  = col_of(b);
            es = {1'b1, c[4:0]};
         end else if (b < k + np) begin
            es = 6'b100000 | (6'd1 << (b - k));
         end else begin
            es = 6'b100000;
         end
         if (syn6(w, k, np) != es) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Monitor: one pop per output transfer, sampled on the falling edge.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%08h, required no output", out_code);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_code", out_code, mon_e.code);
            check("out_err", 32'(out_err), 32'(mon_e.err));
            if (!mon_e.err) check("syndrome", 32'(synd_ok(out_code, mon_e.size)), 32'd1);
         end
         pop_log.push_back(cyc);
      end
   end

   // Called 2 time units after a rising edge; returns at the same phase.
   task automatic send(input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] code, input logic err, output int waits);
      exp_t e;
      bit   acc;
      in_valid = 1'b1;
      in_data  = d;
      in_size  = s;
      waits    = 0;
      acc      = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (!acc) begin
            waits++;
            if (waits > 50) begin
               n_tests++;
               n_fail++;
               $display("FAIL send_timeout: in_ready low for %0d cycles, required acceptance", waits);
               break;
            end
         end
      end
      #2;
      if (acc) begin
         e.code = code;
         e.err  = err;
         e.size = s;
         exp_q.push_back(e);
         last_acc_cyc = cyc;
      end
      in_valid = 1'b0;
      in_data  = 32'h0;
      in_size  = 2'b00;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_drain: %0d words pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int          w, wa, wb, wc, tot_waits, acc0, n0, n_pop;
   logic [31:0] d;
   logic [1:0]  s;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_size = '0; out_ready = 1'b1;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_code", out_code, 32'h0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_enc_count", 32'(enc_count), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Basic encodes; output appears two cycles counting the acceptance cycle.
      send(32'h0000_0001, 2'b00, 32'h0000_1301, 1'b0, w);
      acc0 = last_acc_cyc;
      drain("basic0");
      check("latency", 32'(pop_log[$] - acc0), 32'd1);
      check("count_first", 32'(enc_count), 32'd1);
      send(32'h0000_0001, 2'b01, 32'h0023_0001, 1'b0, w);
      send(32'h0000_0001, 2'b10, 32'h8C00_0001, 1'b0, w);
      send(32'h0200_0000, 2'b10, 32'h7E00_0000, 1'b0, w);
      send(32'h0000_0000, 2'b10, 32'h0000_0000, 1'b0, w);
      drain("basic");
      check("count_basic", 32'(enc_count), 32'd5);

      // Masking of unused bits and the illegal size.
      send(32'hFFFF_FF01, 2'b00, 32'h0000_1301, 1'b0, w);
      send(32'hABCD_0001, 2'b01, 32'h0023_0001, 1'b0, w);
      send(32'hFC00_0001, 2'b10, 32'h8C00_0001, 1'b0, w);
      send(32'h1234_5678, 2'b11, 32'h0000_0000, 1'b1, w);
      drain("mask");
      check("count_mask", 32'(enc_count), 32'd9);

      // Backpressure: A and B fill the pipe, C waits until out_ready returns.
      out_ready = 1'b0;
      fork
         begin
            send(32'h0000_0001, 2'b00, 32'h0000_1301, 1'b0, wa);
            send(32'h0200_0000, 2'b10, 32'h7E00_0000, 1'b0, wb);
            send(32'h0000_0001, 2'b01, 32'h0023_0001, 1'b0, wc);
         end
         begin
            int k;
            k = 0;
            @(negedge clk);
            while (in_ready && k < 20) begin
               @(negedge clk);
               k++;
            end
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_head_code", out_code, 32'h0000_1301);
            repeat (3) begin
               @(negedge clk);
               check("bp_hold_code", out_code, 32'h0000_1301);
               check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            #2 out_ready = 1'b1;
            #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
         end
      join
      drain("bp");
      check("bp_consecutive", 32'(pop_log[$] - pop_log[$-2]), 32'd2);
      check("count_bp", 32'(enc_count), 32'd12);

      // Full throughput with random words of every size.
      n0 = pop_log.size();
      tot_waits = 0;
      for (int i = 0; i < 100; i++) begin
         d = $urandom;
         s = 2'($urandom_range(0, 3));
         send(d, s, ref_code(d, s), (s == 2'b11), w);
         tot_waits += w;
         if (i == 0) acc0 = last_acc_cyc;
      end
      drain("tp");
      check("tp_stalls", 32'(tot_waits), 32'd0);
      check("tp_outputs", 32'(pop_log.size() - n0), 32'd100);
      check("tp_consecutive", 32'(pop_log[$] - pop_log[n0]), 32'd99);
      check("tp_fill", 32'(pop_log[n0] - acc0), 32'd1);
      check("count_tp", 32'(enc_count), 32'd112);

      // Reset with both stages full.
      out_ready = 1'b0;
      send(32'h0000_0001, 2'b10, 32'h8C00_0001, 1'b0, w);
      send(32'h0000_00FF, 2'b00, ref_code(32'h0000_00FF, 2'b00), 1'b0, w);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_out_code", out_code, 32'h0);
      check("async_rst_enc_count", 32'(enc_count), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      n_pop = pop_log.size();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      check("rst_no_stale", 32'(pop_log.size() - n_pop), 32'd0);
      check("rst_out_valid_after", 32'(out_valid), 32'd0);

      // 17 words through a 4-bit counter wrap it to 1.
      for (int i = 0; i < 17; i++) begin
         send(32'(i), 2'b00, ref_code(32'(i), 2'b00), 1'b0, w);
      end
      drain("wrap");
      check("wrap_count4", 32'(w4_enc_count), 32'd1);
      check("wrap_count16", 32'(enc_count), 32'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
